// File: rtl/cfg_chain_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
package cfg_chain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DEF_CHAIN_LEN = 4;
    localparam int DEF_WORD_W    = 32;

    function automatic int nwords(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    function automatic int rem_cnt_w(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    function automatic int bit_cnt_w(input int word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/cfg_chain_loader.sv
// Bit-serial writer for the DSP configuration daisy chain; the previous chain
// contents come back out of the tail as a readback word stream.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | s_ready high, waiting for the next load word
// SHIFT | shifting the current word, stalled while a readback word is pending
// DRAIN | all bits shifted, waiting for the last readback word to be taken
module cfg_chain_loader
    import cfg_chain_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              configuration_input,
    output logic              configuration_enable,
    input  logic              configuration_output,
    output logic              busy,
    output logic              done
);

    localparam int RW = rem_cnt_w(CHAIN_LEN);
    localparam int BW = bit_cnt_w(WORD_W);

    state_t            state;
    logic [WORD_W-1:0] shreg, shreg_nxt;
    logic [WORD_W-1:0] rb, rb_nxt;
    logic [WORD_W-1:0] bit_sel;
    logic [RW-1:0]     rem, rem_nxt;
    logic [BW-1:0]     wcnt, wcnt_nxt;
    logic              mv_hold;

    // configuration_enable high in this cycle means a shift happens on the coming edge
    always_comb begin
        shreg_nxt = shreg;
        rb_nxt    = rb;
        rem_nxt   = rem;
        wcnt_nxt  = wcnt;
        if (configuration_enable) begin
            shreg_nxt = shreg >> 1;
            rb_nxt    = rb | (bit_sel & {WORD_W{configuration_output}});
            rem_nxt   = rem - RW'(1);
            wcnt_nxt  = wcnt - BW'(1);
        end
    end

    assign mv_hold = m_valid & ~m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            shreg                <= '0;
            rb                   <= '0;
            bit_sel              <= '0;
            rem                  <= '0;
            wcnt                 <= '0;
            s_ready              <= 1'b0;
            m_valid              <= 1'b0;
            m_data               <= '0;
            configuration_input  <= 1'b0;
            configuration_enable <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
        end else begin
            shreg                <= shreg_nxt;
            rb                   <= rb_nxt;
            rem                  <= rem_nxt;
            wcnt                 <= wcnt_nxt;
            done                 <= 1'b0;
            configuration_enable <= 1'b0;
            configuration_input  <= 1'b0;
            if (configuration_enable)
                bit_sel <= bit_sel << 1;
            if (m_valid && m_ready)
                m_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        s_ready <= 1'b1;
                        rem     <= RW'(CHAIN_LEN);
                    end
                end
                FETCH: begin
                    if (s_valid) begin
                        shreg   <= s_data;
                        rb      <= '0;
                        bit_sel <= WORD_W'(1);
                        wcnt    <= (int'(rem) >= WORD_W) ? BW'(WORD_W) : BW'(rem);
                        s_ready <= 1'b0;
                        state   <= SHIFT;
                        configuration_enable <= ~mv_hold;
                        configuration_input  <= ~mv_hold & s_data[0];
                    end
                end
                SHIFT: begin
                    if (wcnt_nxt == '0) begin
                        m_valid <= 1'b1;
                        m_data  <= rb_nxt;
                        if (rem_nxt != '0) begin
                            state   <= FETCH;
                            s_ready <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        configuration_enable <= ~mv_hold;
                        configuration_input  <= ~mv_hold & shreg_nxt[0];
                    end
                end
                DRAIN: begin
                    if (m_valid && m_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench: a 4-bit carry-in-manager chain and a 40-bit chain, each
// modelled behaviourally behind its own loader instance.
module tb_cfg_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4_n, start4, sv4, sr4, mv4, mr4, ci4, ce4, co4, busy4, done4;
    logic [31:0] sd4, md4;
    logic        rst40_n, start40, sv40, sr40, mv40, mr40, ci40, ce40, co40, busy40, done40;
    logic [31:0] sd40, md40;

    logic [3:0]  chain4  = '0;
    logic [39:0] chain40 = '0;
    int          en_cnt4  = 0;
    int          en_cnt40 = 0;

    // chain head is the MSB, tail (configuration_output) is bit 0
    always @(posedge clk) begin
        if (ce4) begin
            chain4  <= {ci4, chain4[3:1]};
            en_cnt4 <= en_cnt4 + 1;
        end
        if (ce40) begin
            chain40  <= {ci40, chain40[39:1]};
            en_cnt40 <= en_cnt40 + 1;
        end
    end
    assign co4  = chain4[0];
    assign co40 = chain40[0];

    cfg_chain_loader #(.CHAIN_LEN(4), .WORD_W(32)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .start(start4),
        .s_data(sd4), .s_valid(sv4), .s_ready(sr4),
        .m_data(md4), .m_valid(mv4), .m_ready(mr4),
        .configuration_input(ci4), .configuration_enable(ce4),
        .configuration_output(co4), .busy(busy4), .done(done4)
    );

    cfg_chain_loader #(.CHAIN_LEN(40), .WORD_W(32)) u_dut40 (
        .clk(clk), .rst_n(rst40_n), .start(start40),
        .s_data(sd40), .s_valid(sv40), .s_ready(sr40),
        .m_data(md40), .m_valid(mv40), .m_ready(mr40),
        .configuration_input(ci40), .configuration_enable(ce40),
        .configuration_output(co40), .busy(busy40), .done(done40)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] q4[$];
    logic [31:0] q40[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic f_sr(input int d);   return (d == 0) ? sr4   : sr40;   endfunction
    function automatic logic f_mv(input int d);   return (d == 0) ? mv4   : mv40;   endfunction
    function automatic logic f_ce(input int d);   return (d == 0) ? ce4   : ce40;   endfunction
    function automatic logic f_busy(input int d); return (d == 0) ? busy4 : busy40; endfunction
    function automatic logic f_done(input int d); return (d == 0) ? done4 : done40; endfunction
    function automatic int   f_en(input int d);   return (d == 0) ? en_cnt4 : en_cnt40; endfunction

    task automatic drv(input int d, input logic st, input logic v, input logic [31:0] data, input logic rdy);
        if (d == 0) begin
            start4 = st; sv4 = v; sd4 = data; mr4 = rdy;
        end else begin
            start40 = st; sv40 = v; sd40 = data; mr40 = rdy;
        end
    endtask

    // One complete load; expected readback words are queued by the caller.
    task automatic do_load(input int d, input logic [31:0] w0, input logic [31:0] w1,
                           input int nw, input int gap, input int bp, input bit poke,
                           input bit start_on_done, input bit skip_start, input int chain_len);
        logic        st, sv, mr, sv_d, sr_d, mv_d, mr_d;
        logic [31:0] sd;
        int          wi, en0, gap_n, bp_n;
        bit          fin, gap_wait, gap_bad, bp_armed, bp_bad, resume_pending;
        en0 = f_en(d);
        st = 1'b0; sv = 1'b1; sd = w0; mr = (bp > 0) ? 1'b0 : 1'b1;
        wi = 0; gap_n = 0; bp_n = 0;
        fin = 0; gap_wait = 0; gap_bad = 0; bp_armed = (bp > 0); bp_bad = 0; resume_pending = 0;
        if (!skip_start) begin
            @(posedge clk); #1; drv(d, 1'b1, sv, sd, mr);
            @(posedge clk); #1; drv(d, 1'b0, sv, sd, mr);
            chk("start_busy_ready", {f_busy(d), f_sr(d)}, 2'b11);
        end else begin
            drv(d, 1'b0, sv, sd, mr);
        end
        sv_d = sv; sr_d = f_sr(d); mv_d = f_mv(d); mr_d = mr;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(posedge clk); #1;
            st = poke && (cyc == 2);
            if (sv_d && sr_d) begin
                chk($sformatf("w%0d_first_en", wi), f_ce(d), (wi == 0 || bp == 0) ? 1 : 0);
                wi++;
                if (wi < nw) begin
                    if (gap == 0) begin sv = 1'b1; sd = w1; end
                    else begin sv = 1'b0; gap_wait = 1; end
                end else begin
                    sv = 1'b0;
                end
            end
            if (resume_pending && mv_d && mr_d) begin
                chk("bp_resume_en", f_ce(d), 1);
                resume_pending = 0;
            end
            if (gap_wait && f_sr(d)) begin
                if (f_ce(d)) gap_bad = 1;
                gap_n++;
                if (gap_n == gap) begin sv = 1'b1; sd = w1; gap_wait = 0; end
            end
            if (bp_armed && f_mv(d)) begin
                if (f_ce(d)) bp_bad = 1;
                bp_n++;
                if (bp_n == bp) begin mr = 1'b1; bp_armed = 0; resume_pending = 1; end
            end
            if (f_done(d)) begin
                chk("done_busy_low", f_busy(d), 0);
                fin = 1;
                if (start_on_done) st = 1'b1;
            end
            drv(d, st, sv, sd, mr);
            sv_d = sv; sr_d = f_sr(d); mv_d = f_mv(d); mr_d = mr;
        end
        chk("load_done_seen", fin, 1);
        chk("enable_count", f_en(d) - en0, chain_len);
        if (gap > 0) chk("starve_no_en", gap_bad, 0);
        if (bp > 0)  chk("bp_no_en", bp_bad, 0);
        @(posedge clk); #1;
        if (start_on_done) begin
            drv(d, 1'b0, 1'b0, 32'h0, 1'b1);
            chk("restart_on_done", {f_busy(d), f_sr(d)}, 2'b11);
        end else begin
            chk("idle_after_done", f_busy(d), 0);
        end
    endtask

    initial begin
        int en0;
        rst4_n = 1'b0; rst40_n = 1'b0;
        drv(0, 1'b0, 1'b0, 32'h0, 1'b1);
        drv(1, 1'b0, 1'b0, 32'h0, 1'b1);

        fork
            forever begin
                @(negedge clk);
                if (mv4 === 1'b1 && mr4 === 1'b1) begin
                    chk("rb4_pending", q4.size() > 0, 1);
                    if (q4.size() > 0) chk("rb4_word", md4, q4.pop_front());
                end
                if (mv40 === 1'b1 && mr40 === 1'b1) begin
                    chk("rb40_pending", q40.size() > 0, 1);
                    if (q40.size() > 0) chk("rb40_word", md40, q40.pop_front());
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs4",  {sr4, mv4, md4, ci4, ce4, busy4, done4}, 0);
        chk("reset_outputs40", {sr40, mv40, md40, ci40, ce40, busy40, done40}, 0);
        rst4_n = 1'b1; rst40_n = 1'b1;

        // 4-bit chain: start poked mid-load, then back-to-back restart in the done cycle
        q4.push_back(32'h0);
        do_load(0, 32'h5, 32'h0, 1, 0, 0, 1, 0, 0, 4);
        chk("chain4_img_5", chain4, 4'h5);
        q4.push_back(32'h5);
        do_load(0, 32'hA, 32'h0, 1, 0, 0, 0, 1, 0, 4);
        chk("chain4_img_A", chain4, 4'hA);
        chk("CARRYINREG", chain4[3], 1);
        chk("MREG", chain4[2], 0);
        chk("IS_CARRYIN_INVERTED", chain4[1], 1);
        chk("IS_RSTALLCARRYIN_INVERTED", chain4[0], 0);
        q4.push_back(32'hA);
        do_load(0, 32'h3, 32'h0, 1, 0, 0, 0, 0, 1, 4);
        chk("chain4_img_3", chain4, 4'h3);

        // reset after two of four shifts of 0x6: chain 0011 -> 0001 -> 1000
        en0 = en_cnt4;
        @(posedge clk); #1; drv(0, 1'b1, 1'b1, 32'h6, 1'b1);
        @(posedge clk); #1; drv(0, 1'b0, 1'b1, 32'h6, 1'b1);
        for (int i = 0; i < 20 && (en_cnt4 - en0) < 2; i++) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_shifts", en_cnt4 - en0, 2);
        #2 rst4_n = 1'b0;
        #1;
        chk("async_reset_outputs", {sr4, mv4, md4, ci4, ce4, busy4, done4}, 0);
        drv(0, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("no_en_in_reset", en_cnt4 - en0, 2);
        chk("chain4_partial", chain4, 4'h8);
        rst4_n = 1'b1;
        q4.push_back(32'h8);
        do_load(0, 32'h9, 32'h0, 1, 0, 0, 0, 0, 0, 4);
        chk("chain4_img_9", chain4, 4'h9);
        chk("q4_drained", q4.size(), 0);

        // 40-bit chain: starvation gaps and readback backpressure
        q40.push_back(32'h0); q40.push_back(32'h0);
        do_load(1, 32'hDEADBEEF, 32'hFFFFFF5A, 2, 5, 0, 0, 0, 0, 40);
        chk("chain40_img1", chain40, {8'h5A, 32'hDEADBEEF});
        q40.push_back(32'hDEADBEEF); q40.push_back(32'h0000005A);
        do_load(1, 32'h0, 32'h0, 2, 0, 10, 0, 0, 0, 40);
        chk("chain40_img2", chain40, 40'h0);
        q40.push_back(32'h0); q40.push_back(32'h0);
        do_load(1, 32'h12345678, 32'h000000C3, 2, 0, 10, 0, 0, 0, 40);
        chk("chain40_img3", chain40, {8'hC3, 32'h12345678});
        q40.push_back(32'h12345678); q40.push_back(32'h000000C3);
        do_load(1, 32'hA5A5A5A5, 32'h0000000F, 2, 3, 0, 0, 0, 0, 40);
        chk("chain40_img4", chain40, {8'h0F, 32'hA5A5A5A5});
        chk("q40_drained", q40.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
